// File: rtl/dac_pulse_generator_if.sv
// dac_pulse_generator_if: value/GPIO inputs and DAC word outputs of the pulse generator.
// master drives stimulus, slave is the generator itself.
interface dac_pulse_generator_if #(
    parameter int NUM_BITS = 8,
    parameter int SAMPLE_W = 16,
    parameter int SAMPLES  = 16
);
    logic [NUM_BITS-1:0]         val_in;
    logic                        val_in_valid;
    logic [31:0]                 gpio_in;
    logic [SAMPLES*SAMPLE_W-1:0] dac_word_out;
    logic                        dac_valid_out;
    logic [31:0]                 pulse_count;

    modport master (
        output val_in,
        output val_in_valid,
        output gpio_in,
        input  dac_word_out,
        input  dac_valid_out,
        input  pulse_count
    );

    modport slave (
        input  val_in,
        input  val_in_valid,
        input  gpio_in,
        output dac_word_out,
        output dac_valid_out,
        output pulse_count
    );
endinterface

// File: rtl/dac_pulse_generator.sv
// dac_pulse_generator: GPIO-programmed LUT shaped into a pulse across a multi-sample DAC word.
// Build option DAC_PULSE_RAMP_EN halves the first and last samples of pulses of length >= 2.
module dac_pulse_generator #(
    parameter int NUM_BITS = 8,
    parameter int SAMPLE_W = 16,
    parameter int SAMPLES  = 16,
    parameter int ADDR_REG = 0,
    parameter int DATA_REG = 1,
    parameter int CTRL_REG = 2
) (
    input logic                  clk,
    input logic                  rst,
    dac_pulse_generator_if.slave bus
);
    localparam int DEPTH  = 1 << NUM_BITS;
    localparam int WORD_W = SAMPLES * SAMPLE_W;

    localparam logic [7:0] ADDR_SEL = 8'(ADDR_REG);
    localparam logic [7:0] DATA_SEL = 8'(DATA_REG);
    localparam logic [7:0] CTRL_SEL = 8'(CTRL_REG);

    logic [7:0]  sel;
    logic [15:0] payload;
    logic        stb;
    logic        unused_gpio;

    assign sel         = bus.gpio_in[7:0];
    assign payload     = bus.gpio_in[23:8];
    assign stb         = bus.gpio_in[24];
    assign unused_gpio = &{1'b0, bus.gpio_in[31:25]};

    logic                strobe_q, strobe_d;
    logic [NUM_BITS-1:0] ptr_q, ptr_d;
    logic [3:0]          start_q, start_d;
    logic [4:0]          len_q, len_d;
    logic                wr_en;
    logic                lut_we;

    logic [SAMPLE_W-1:0] lut_q [DEPTH];

    logic                s1_valid_q, s1_valid_d;
    logic [SAMPLE_W-1:0] s1_data_q, s1_data_d;
    logic [3:0]          s1_start_q, s1_start_d;
    logic [4:0]          s1_len_q, s1_len_d;

    logic [WORD_W-1:0]   word_q, word_d;
    logic                dvalid_q, dvalid_d;
    logic [31:0]         count_q, count_d;

    // Register writes fire only on the 0->1 transition of the strobe.
    always_comb begin
        strobe_d = stb;
        wr_en    = stb & ~strobe_q & ~rst;
        ptr_d    = ptr_q;
        start_d  = start_q;
        len_d    = len_q;
        lut_we   = 1'b0;
        if (wr_en) begin
            unique case (1'b1)
                (sel == ADDR_SEL): begin
                    ptr_d = payload[NUM_BITS-1:0];
                end
                (sel == DATA_SEL): begin
                    lut_we = 1'b1;
                    ptr_d  = ptr_q + NUM_BITS'(1);
                end
                (sel == CTRL_SEL): begin
                    start_d = payload[3:0];
                    len_d   = payload[8:4];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_q <= 1'b0;
            ptr_q    <= '0;
            start_q  <= 4'd6;
            len_q    <= 5'd4;
        end else begin
            strobe_q <= strobe_d;
            ptr_q    <= ptr_d;
            start_q  <= start_d;
            len_q    <= len_d;
        end
    end

    // LUT keeps its contents through reset; a same-edge read sees the old entry.
    always_ff @(posedge clk) begin
        if (lut_we) begin
            lut_q[ptr_q] <= payload[SAMPLE_W-1:0];
        end
    end

    always_comb begin
        s1_valid_d = bus.val_in_valid;
        s1_data_d  = lut_q[bus.val_in];
        s1_start_d = start_q;
        s1_len_d   = len_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_start_q <= '0;
            s1_len_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_start_q <= s1_start_d;
            s1_len_q   <= s1_len_d;
        end
    end

    // Pulse spans start..start+len-1, clipped at the top sample, never wrapped.
    always_comb begin
        int first;
        int last;
        first    = int'(s1_start_q);
        last     = first + int'(s1_len_q) - 1;
        if (last > SAMPLES - 1) begin
            last = SAMPLES - 1;
        end
        word_d   = '0;
        dvalid_d = s1_valid_q && (s1_len_q != '0);
        if (dvalid_d) begin
            for (int i = 0; i < SAMPLES; i++) begin
                if (i >= first && i <= last) begin
                    word_d[i*SAMPLE_W +: SAMPLE_W] = s1_data_q;
`ifdef DAC_PULSE_RAMP_EN
                    if (last > first && (i == first || i == last)) begin
                        word_d[i*SAMPLE_W +: SAMPLE_W] =
                            $unsigned($signed(s1_data_q) >>> 1);
                    end
`endif
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (dvalid_d && count_q != '1) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q   <= '0;
            dvalid_q <= 1'b0;
            count_q  <= '0;
        end else begin
            word_q   <= word_d;
            dvalid_q <= dvalid_d;
            count_q  <= count_d;
        end
    end

    assign bus.dac_word_out  = word_q;
    assign bus.dac_valid_out = dvalid_q;
    assign bus.pulse_count   = count_q;
endmodule

// File: tb/tb_dac_pulse_generator.sv
// tb_dac_pulse_generator: randomized + directed stimulus, queue scoreboard
// against a behavioural LUT/pulse model.
module tb_dac_pulse_generator;
    localparam int NB = 8;
    localparam int SW = 16;
    localparam int NS = 16;
    localparam logic [7:0] A_SEL = 8'd0;
    localparam logic [7:0] D_SEL = 8'd1;
    localparam logic [7:0] C_SEL = 8'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dac_pulse_generator_if #(.NUM_BITS(NB), .SAMPLE_W(SW), .SAMPLES(NS)) bus ();

    dac_pulse_generator #(
        .NUM_BITS(NB), .SAMPLE_W(SW), .SAMPLES(NS),
        .ADDR_REG(0), .DATA_REG(1), .CTRL_REG(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS*SW-1:0] word;
        int               due;
        logic [31:0]      cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    logic [SW-1:0] mlut [256];
    logic [7:0]    mptr;
    logic [3:0]    mstart;
    logic [4:0]    mlen;
    logic          mprev;
    logic [31:0]   mcnt;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NS*SW-1:0] exp_word(
        input logic [SW-1:0] v, input logic [3:0] st, input logic [4:0] ln);
        logic [NS*SW-1:0] w;
        int first;
        int last;
        w     = '0;
        first = int'(st);
        last  = first + int'(ln) - 1;
        if (last > NS - 1) last = NS - 1;
        for (int i = first; i <= last; i++) begin
            w[i*SW +: SW] = v;
`ifdef DAC_PULSE_RAMP_EN
            if (last > first && (i == first || i == last))
                w[i*SW +: SW] = $unsigned($signed(v) >>> 1);
`endif
        end
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    // One clock of stimulus; the model reads before it applies any write.
    task automatic step(input logic v, input logic [7:0] vi,
                        input logic [7:0] sel, input logic [15:0] pl, input logic s);
        exp_t e;
        @(posedge clk);
        #1;
        bus.val_in_valid = v;
        bus.val_in       = vi;
        bus.gpio_in      = {7'd0, s, pl, sel};
        if (v && mlen != 0) begin
            mcnt++;
            e.word = exp_word(mlut[vi], mstart, mlen);
            e.due  = cyc + 2;
            e.cnt  = mcnt;
            q.push_back(e);
        end
        if (s && !mprev) begin
            if (sel == A_SEL) begin
                mptr = pl[7:0];
            end else if (sel == D_SEL) begin
                mlut[mptr] = pl;
                mptr = mptr + 8'd1;
            end else if (sel == C_SEL) begin
                mstart = pl[3:0];
                mlen   = pl[8:4];
            end
        end
        mprev = s;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'd0, 8'd0, 16'd0, 1'b0);
    endtask

    task automatic wr(input logic [7:0] sel, input logic [15:0] pl);
        step(1'b0, 8'd0, sel, pl, 1'b1);
        step(1'b0, 8'd0, sel, pl, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst              = 1'b1;
        bus.val_in_valid = 1'b0;
        bus.val_in       = '0;
        bus.gpio_in      = '0;
        q.delete();
        mcnt   = 0;
        mptr   = 0;
        mstart = 4'd6;
        mlen   = 5'd4;
        mprev  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, bus.dac_valid_out}, 32'd0);
        chk("rst_word_nonzero", {31'd0, |bus.dac_word_out}, 32'd0);
        chk("rst_count", bus.pulse_count, 32'd0);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (q.size() > 0 && q[0].due < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL missing_pulse: no pulse by cycle %0d, required at cycle %0d",
                         cyc, q[0].due);
                void'(q.pop_front());
            end
            if (bus.dac_valid_out) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pulse: actual word %h at cycle %0d, required no pulse",
                             bus.dac_word_out, cyc);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.due != cyc || bus.dac_word_out !== mon_e.word ||
                        bus.pulse_count !== mon_e.cnt) begin
                        n_err++;
                        $display("FAIL pulse: actual cyc %0d word %h cnt %0d, required cyc %0d word %h cnt %0d",
                                 cyc, bus.dac_word_out, bus.pulse_count,
                                 mon_e.due, mon_e.word, mon_e.cnt);
                    end
                end
            end else begin
                n_vec++;
                if (bus.dac_word_out !== '0) begin
                    n_err++;
                    $display("FAIL idle_word: actual %h required 0", bus.dac_word_out);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        bus.val_in_valid = 1'b0;
        bus.val_in       = '0;
        bus.gpio_in      = '0;
        do_reset();

        wr(A_SEL, 16'h0000);
        for (int i = 0; i < 256; i++) wr(D_SEL, 16'($urandom));

        // Default 6/4 pulse right after reset
        wr(A_SEL, 16'h0005);
        wr(D_SEL, 16'h1234);
        step(1'b1, 8'd5, 8'd0, 16'd0, 1'b0);
        idle(4);
        chk("first_count", bus.pulse_count, 32'd1);

        // Clipped at the top sample, then zero length
        wr(A_SEL, 16'h0000);
        wr(D_SEL, 16'h7FFF);
        wr(C_SEL, 16'h004E);
        step(1'b1, 8'd0, 8'd0, 16'd0, 1'b0);
        idle(3);
        wr(C_SEL, 16'h000E);
        step(1'b1, 8'd0, 8'd0, 16'd0, 1'b0);
        idle(4);
        chk("len0_count", bus.pulse_count, 32'd2);

        // Pointer wrap
        wr(C_SEL, 16'h0100);
        wr(A_SEL, 16'h00FF);
        wr(D_SEL, 16'hA1A1);
        wr(D_SEL, 16'hB2B2);
        wr(D_SEL, 16'hC3C3);
        step(1'b1, 8'hFF, 8'd0, 16'd0, 1'b0);
        step(1'b1, 8'h00, 8'd0, 16'd0, 1'b0);
        step(1'b1, 8'h01, 8'd0, 16'd0, 1'b0);

        // Held strobe writes once
        wr(A_SEL, 16'h0020);
        for (int i = 0; i < 10; i++) step(1'b0, 8'd0, D_SEL, 16'h5A50 + 16'(i), 1'b1);
        step(1'b0, 8'd0, D_SEL, 16'h0000, 1'b0);
        step(1'b1, 8'h20, 8'd0, 16'd0, 1'b0);
        step(1'b1, 8'h21, 8'd0, 16'd0, 1'b0);
        idle(4);

        // Back-to-back pulses from a fresh reset
        do_reset();
        wr(A_SEL, 16'h0001);
        wr(D_SEL, 16'h1111);
        wr(D_SEL, 16'h2222);
        wr(D_SEL, 16'h3333);
        step(1'b1, 8'd1, 8'd0, 16'd0, 1'b0);
        step(1'b1, 8'd2, 8'd0, 16'd0, 1'b0);
        step(1'b1, 8'd3, 8'd0, 16'd0, 1'b0);
        idle(4);
        chk("b2b_count", bus.pulse_count, 32'd3);

        // Write and read of one entry on the same edge
        wr(A_SEL, 16'h0007);
        step(1'b1, 8'd7, D_SEL, 16'hBEEF, 1'b1);
        step(1'b1, 8'd7, D_SEL, 16'hBEEF, 1'b0);
        idle(4);

        // Reset with a pulse in flight
        wr(C_SEL, 16'h0032);
        step(1'b1, 8'd3, 8'd0, 16'd0, 1'b0);
        do_reset();
        idle(3);
        chk("flushed_count", bus.pulse_count, 32'd0);
        step(1'b1, 8'd3, 8'd0, 16'd0, 1'b0);
        idle(4);

        // Ramp-shaped short pulse of a negative value
        wr(A_SEL, 16'h0009);
        wr(D_SEL, 16'h8000);
        wr(C_SEL, 16'h0030);
        step(1'b1, 8'd9, 8'd0, 16'd0, 1'b0);
        idle(4);

        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 8'($urandom_range(0, 3)), 16'($urandom),
                 1'($urandom_range(0, 1)));
        end
        idle(6);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dac_pulse_generator.md
DAC_PULSE_GENERATOR -- requirements
Module: dac_pulse_generator

Interface
REQ-001 SHALL have parameter NUM_BITS, default 8: width of val_in and of the LUT address (2^NUM_BITS entries).
REQ-002 SHALL have parameter SAMPLE_W, default 16: width of one DAC sample and of one LUT entry.
REQ-003 SHALL have parameter SAMPLES, default 16: samples per DAC word; dac_word_out width is SAMPLES*SAMPLE_W.
REQ-004 SHALL have parameters ADDR_REG, default 0; DATA_REG, default 1; CTRL_REG, default 2: GPIO register selects.
REQ-005 SHALL have port clk, input, 1: the single clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset is asynchronous and active-high.
REQ-007 SHALL have port val_in, input, NUM_BITS: LUT index.
REQ-008 SHALL have port val_in_valid, input, 1: val_in qualifier.
REQ-009 SHALL have port gpio_in, input, 32: [7:0] register select, [23:8] payload, [24] write strobe.
REQ-010 SHALL have port dac_word_out, output, SAMPLES*SAMPLE_W: sample 0 at bits [SAMPLE_W-1:0].
REQ-011 SHALL have port dac_valid_out, output, 1: high when dac_word_out carries a pulse.
REQ-012 SHALL have port pulse_count, output, 32: count of pulses emitted.

Function
REQ-013 SHALL register gpio_in[24] and perform a register write only on the cycle its rising edge is detected (0 then 1).
REQ-014 SHALL load the LUT write pointer from payload[NUM_BITS-1:0] on a write to ADDR_REG.
REQ-015 SHALL write payload[SAMPLE_W-1:0] to LUT[pointer] on a write to DATA_REG, then increment the pointer modulo 2^NUM_BITS.
REQ-016 SHALL load pulse_start = payload[3:0] and pulse_len = payload[8:4] on a write to CTRL_REG; other select values are ignored.
REQ-017 SHALL have a fixed latency of 2: val_in_valid at edge N -> LUT read registered at N+1 -> dac_word_out/dac_valid_out at N+2.
REQ-018 SHALL fully pipeline input, accepting val_in_valid on every cycle.
REQ-019 SHALL fill samples pulse_start..min(pulse_start+pulse_len-1, SAMPLES-1) with the LUT value, with no wrap-around; all other samples 0.
REQ-020 SHALL drive dac_word_out = 0 and dac_valid_out = 0 when the pipelined valid is low, or when pulse_len = 0.
REQ-021 SHALL use the pulse_start and pulse_len values sampled at the cycle val_in_valid was accepted, so a CTRL write is atomic per pulse.
REQ-022 SHALL, when a LUT write and a read hit the same address in one cycle, return the old entry (read-before-write).
REQ-023 SHALL increment pulse_count once per cycle dac_valid_out is high, saturating at 0xFFFFFFFF.

Reset
REQ-024 SHALL, while rst is high, force dac_word_out = 0, dac_valid_out = 0, pulse_count = 0, pipeline valids = 0, write pointer = 0, strobe register = 0, pulse_start = 6, pulse_len = 4 (centred 4-sample pulse).
REQ-025 SHALL retain LUT contents across reset; after power-up the LUT is undefined until written.
REQ-026 SHALL discard in-flight pulses when reset is asserted mid-operation; the first output after release follows REQ-017.

Configuration
REQ-027 SHALL use the macro DAC_PULSE_RAMP_EN.
REQ-028 SHALL, with DAC_PULSE_RAMP_EN defined and an effective pulse length >= 2, drive the first and last pulse samples to the LUT value arithmetically shifted right by 1 (signed); a length of 1 stays at full value.
REQ-029 SHALL, without DAC_PULSE_RAMP_EN, drive all pulse samples at full LUT value.

Verification
REQ-030 SHALL cover: write ADDR=0x05, DATA=0x1234, valid with val_in=5 -> two cycles later samples 6..9 = 0x1234, others 0, dac_valid_out=1, pulse_count=1.
REQ-031 SHALL cover: CTRL start=14, len=4, LUT[0]=0x7FFF, val_in=0 -> only samples 14,15 = 0x7FFF (clipped, no wrap); len=0 -> dac_valid_out=0, word 0.
REQ-032 SHALL cover: three DATA writes after ADDR=0xFF -> entries 0xFF, 0x00, 0x01 written (pointer wrap); strobe held high for 10 cycles -> exactly one write.
REQ-033 SHALL cover: back-to-back valids val_in=1,2,3 with distinct LUT entries -> three consecutive pulses, in order, pulse_count=3; same-cycle write/read of an entry -> old value output.
REQ-034 SHALL cover: rst asserted one cycle after a valid -> no pulse emitted, pulse_count=0, start/len = 6/4.
REQ-035 SHALL cover, with DAC_PULSE_RAMP_EN: LUT=0x8000, start=0, len=3 -> samples 0x C000, 0x8000, 0xC000.
